// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and grant indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        XFER_CORE = 2'b01,
        XFER_DMA  = 2'b10
    } arb_state_e;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_DMA  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the unified instruction/data memory between the multicycle core and a DMA port.
// One transaction at a time: latch in IDLE, drive memory until mem_ready or timeout, ack, return.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

    logic          gnt_valid;
    logic          gnt_sel;
    logic          timed_out;

    // Core has priority unless DMA has already waited out STARVE_LIMIT core grants.
    always_comb begin
        gnt_valid = core_req | dma_req;
        gnt_sel   = GNT_CORE;
        if (dma_req && (!core_req || starve_q == STARVE_MAX)) begin
            gnt_sel = GNT_DMA;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        starve_d     = starve_q;
        timer_d      = timer_q;
        core_rdata_d = core_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        core_ack     = 1'b0;
        dma_ack      = 1'b0;
        bus_err      = 1'b0;
        timed_out    = (TIMEOUT > 0) && (timer_q == TIMER_LAST) && !mem_ready;

        unique case (state_q)
            IDLE: begin
                timer_d  = '0;
                starve_d = '0;
                if (gnt_valid) begin
                    if (gnt_sel == GNT_DMA) begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                        state_d = XFER_DMA;
                    end else begin
                        we_d    = core_we;
                        addr_d  = core_addr;
                        wdata_d = core_wdata;
                        state_d = XFER_CORE;
                        // Counts only grants that made a waiting DMA lose; saturates.
                        if (dma_req) begin
                            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);
                        end
                    end
                end
            end
            XFER_CORE, XFER_DMA: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                timer_d = timer_q + TW'(1);
                if (mem_ready || timed_out) begin
                    bus_err = timed_out;
                    state_d = IDLE;
                    if (state_q == XFER_CORE) begin
                        core_ack = 1'b1;
                        if (mem_ready && !we_q) core_rdata_d = mem_rdata;
                    end else begin
                        dma_ack = 1'b1;
                        if (mem_ready && !we_q) dma_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_q     <= '0;
            timer_q      <= '0;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            starve_q     <= starve_d;
            timer_q      <= timer_d;
            core_rdata_q <= core_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_rdata = core_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign core_stall = core_req & ~core_ack;

endmodule
